// File: rtl/bram_tdp_be.sv
// True dual-port block RAM: byte-lane writes, pipelined reads with a
// valid pulse, and a selectable read-during-write mode.
package bram_pkg;
  typedef enum logic [1:0] {NC, RF, WF} mode_e;
endpackage

module bram_rd_pipe #(
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          v_i,
  input  logic [DW-1:0] d_i,
  output logic          v_o,
  output logic [DW-1:0] d_o
);
  logic [LATENCY-1:0] v_q;
  logic [DW-1:0]      d_q [LATENCY];
  logic [LATENCY-1:0] sv;
  logic [DW-1:0]      sd [LATENCY];

  always_comb begin
    sv = '0;
    for (int i = 0; i < LATENCY; i++) sd[i] = '0;
    sv[0] = v_i;
    sd[0] = d_i;
    for (int i = 1; i < LATENCY; i++) begin
      sv[i] = v_q[i-1];
      sd[i] = d_q[i-1];
    end
  end

  // The last stage is the output register: it only loads on a valid beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q <= sv;
      for (int i = 0; i < LATENCY - 1; i++) d_q[i] <= sd[i];
      if (sv[LATENCY-1]) d_q[LATENCY-1] <= sd[LATENCY-1];
    end
  end

  assign v_o = v_q[LATENCY-1];
  assign d_o = d_q[LATENCY-1];
endmodule

module bram_tdp_be
  import bram_pkg::*;
#(
  parameter int    DW        = 32,
  parameter int    BW        = 8,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter mode_e MODE      = NC,
  parameter string INIT_FILE = "",
  localparam int   NB        = DW / BW,
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ena,
  input  logic [NB-1:0] wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  output logic          valida,
  input  logic          enb,
  input  logic [NB-1:0] web,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dinb,
  output logic [DW-1:0] doutb,
  output logic          validb,
  output logic          coll
);
  logic [DW-1:0] mem [DEPTH];

  logic          a_ok, b_ok, a_wr, b_wr;
  logic          a_qual, b_qual, coll_d, coll_q;
  logic [DW-1:0] a_old, b_old, a_rd, b_rd;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] din,
    input logic [NB-1:0] we
  );
    merge = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) merge[i*BW +: BW] = din[i*BW +: BW];
  endfunction

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  assign a_ok   = 32'(addra) < 32'(DEPTH);
  assign b_ok   = 32'(addrb) < 32'(DEPTH);
  assign a_wr   = ena && a_ok && (wea != '0);
  assign b_wr   = enb && b_ok && (web != '0);
  assign a_qual = ena && (MODE != NC || wea == '0);
  assign b_qual = enb && (MODE != NC || web == '0);
  assign coll_d = ena && enb && (addra == addrb)
               && (wea != '0) && (web != '0);

  always_comb begin
    a_old = '0;
    b_old = '0;
    if (a_ok) a_old = mem[addra];
    if (b_ok) b_old = mem[addrb];
    a_rd = a_old;
    b_rd = b_old;
    if (MODE == WF) begin
      if (a_ok) a_rd = merge(a_old, dina, wea);
      if (b_ok) b_rd = merge(b_old, dinb, web);
    end
  end

  // A is applied after B so it wins every lane both ports enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b_wr && web[i]) mem[addrb][i*BW +: BW] <= dinb[i*BW +: BW];
      if (a_wr && wea[i]) mem[addra][i*BW +: BW] <= dina[i*BW +: BW];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) coll_q <= 1'b0;
    else       coll_q <= coll_d;
  end

  assign coll = coll_q;

  bram_rd_pipe #(.DW(DW), .LATENCY(LATENCY)) u_pa (
    .clk(clk), .rstn(rstn),
    .v_i(a_qual), .d_i(a_rd),
    .v_o(valida), .d_o(douta)
  );

  bram_rd_pipe #(.DW(DW), .LATENCY(LATENCY)) u_pb (
    .clk(clk), .rstn(rstn),
    .v_i(b_qual), .d_i(b_rd),
    .v_o(validb), .d_o(doutb)
  );
endmodule

// File: tb/tb_bram_tdp_be.sv
// Bench for bram_tdp_be: four instances (NC/RF/WF at latency 2, NC at
// latency 3 with depth 20) share stimulus and are checked by a scoreboard.
module tb_bram_tdp_be;
  import bram_pkg::*;

  localparam int ND = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rn;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [5:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] dout [8];
  logic        val  [8];
  logic        coll [ND];

  exp_t        q [8][$];
  exp_t        e_m;
  logic [31:0] refm [ND][32];
  logic [31:0] last [8];
  bit          cexp [ND];
  int          cyc = 0;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bram_tdp_be #(.DEPTH(64), .LATENCY(2), .MODE(NC)) u_nc (
    .clk(clk), .rstn(rstn),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[0]), .valida(val[0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(dout[1]), .validb(val[1]), .coll(coll[0])
  );

  bram_tdp_be #(.DEPTH(64), .LATENCY(2), .MODE(RF)) u_rf (
    .clk(clk), .rstn(rstn),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[2]), .valida(val[2]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(dout[3]), .validb(val[3]), .coll(coll[1])
  );

  bram_tdp_be #(.DEPTH(64), .LATENCY(2), .MODE(WF)) u_wf (
    .clk(clk), .rstn(rstn),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[4]), .valida(val[4]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(dout[5]), .validb(val[5]), .coll(coll[2])
  );

  bram_tdp_be #(.DEPTH(20), .LATENCY(3), .MODE(NC)) u_l3 (
    .clk(clk), .rstn(rstn),
    .ena(ena), .wea(wea), .addra(addra[4:0]), .dina(dina),
    .douta(dout[6]), .valida(val[6]),
    .enb(enb), .web(web), .addrb(addrb[4:0]), .dinb(dinb),
    .doutb(dout[7]), .validb(val[7]), .coll(coll[3])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mode_e md(input int d);
    return d == 1 ? RF : d == 2 ? WF : NC;
  endfunction

  function automatic int lat(input int d);
    return d == 3 ? 3 : 2;
  endfunction

  function automatic int dep(input int d);
    return d == 3 ? 20 : 64;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o,
                                      input logic [31:0] di,
                                      input logic [3:0]  we);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[i*8 +: 8] = di[i*8 +: 8];
    return r;
  endfunction

  task automatic model();
    logic [31:0] oa, ob, xa, xb;
    bit          ka, kb;
    for (int d = 0; d < ND; d++) begin
      ka = int'(addra) < dep(d);
      kb = int'(addrb) < dep(d);
      oa = ka ? refm[d][addra[4:0]] : 32'h0;
      ob = kb ? refm[d][addrb[4:0]] : 32'h0;
      xa = (md(d) == WF && ka) ? mrg(oa, dina, wea) : oa;
      xb = (md(d) == WF && kb) ? mrg(ob, dinb, web) : ob;
      if (rstn && ena && (md(d) != NC || wea == 0))
        q[2*d].push_back('{due: cyc + lat(d), data: xa});
      if (rstn && enb && (md(d) != NC || web == 0))
        q[2*d+1].push_back('{due: cyc + lat(d), data: xb});
      cexp[d] = rstn && ena && enb && addra == addrb
             && wea != 0 && web != 0;
      if (enb && kb) refm[d][addrb[4:0]] = mrg(refm[d][addrb[4:0]], dinb, web);
      if (ena && ka) refm[d][addra[4:0]] = mrg(refm[d][addra[4:0]], dina, wea);
    end
  endtask

  task automatic drv(input bit ea, input logic [3:0] wa,
                     input logic [5:0] aa, input logic [31:0] da,
                     input bit eb, input logic [3:0] wb,
                     input logic [5:0] ab, input logic [31:0] db);
    @(negedge clk);
    #1;
    rstn  = rn;
    ena   = ea;
    wea   = wa;
    addra = aa;
    dina  = da;
    enb   = eb;
    web   = wb;
    addrb = ab;
    dinb  = db;
    model();
  endtask

  task automatic idle(input int n = 1);
    repeat (n) drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (!rstn) begin
        chk($sformatf("rst_dout%0d", k), dout[k], 0);
        chk($sformatf("rst_val%0d", k), val[k], 0);
        q[k].delete();
        last[k] = '0;
      end else begin
        if (q[k].size() > 0 && q[k][0].due < cyc) begin
          chk($sformatf("late%0d", k), cyc, q[k][0].due);
          void'(q[k].pop_front());
        end
        if (val[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("spur%0d", k), val[k], 0);
            last[k] = dout[k];
          end else begin
            e_m = q[k].pop_front();
            chk($sformatf("due%0d", k), cyc, e_m.due);
            chk($sformatf("data%0d", k), dout[k], e_m.data);
            last[k] = e_m.data;
          end
        end else begin
          chk($sformatf("hold%0d", k), dout[k], last[k]);
        end
      end
    end
    for (int d = 0; d < ND; d++)
      chk($sformatf("coll%0d", d), coll[d], rstn ? cexp[d] : 1'b0);
  end

  initial begin
    for (int d = 0; d < ND; d++)
      for (int a = 0; a < 32; a++) refm[d][a] = '0;
    for (int k = 0; k < 8; k++) last[k] = '0;
    for (int d = 0; d < ND; d++) cexp[d] = 1'b0;
    rstn = 1'b1;
    rn   = 1'b0;
    {ena, enb, wea, web, addra, addrb, dina, dinb} = '0;
    #1 rstn = 1'b0;
    idle(3);
    chk("reset_douta", dout[0], 0);
    chk("reset_coll", coll[0], 0);
    rn = 1'b1;

    for (int a = 0; a < 32; a++)
      drv(1, 4'hF, 6'(a), 32'(a), 0, 0, 0, 0);
    idle(4);

    for (int i = 0; i < 18; i++) begin
      if (i < 16) drv(1, 0, 6'(i), 0, 0, 0, 0, 0);
      else        idle();
      if (i >= 2) begin
        chk("stream_val", val[0], 1);
        chk("stream_data", dout[0], 32'(i - 2));
      end
    end
    idle(3);

    drv(1, 4'hF, 6'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    drv(1, 4'h0, 6'd5, 0, 0, 0, 0, 0);
    idle();
    chk("rd5_early", val[0], 0);
    idle();
    chk("rd5_val", val[0], 1);
    chk("rd5_data", dout[0], 32'hDEADBEEF);
    chk("rd5_validb", val[1], 0);
    idle(2);

    drv(1, 4'hF, 6'd7, 32'h11223344, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 4'h5, 6'd7, 32'hAABBCCDD);
    drv(1, 4'h0, 6'd7, 0, 0, 0, 0, 0);
    idle(2);
    chk("lanes", dout[0], 32'h11BB33DD);
    idle(2);

    drv(1, 4'h3, 6'd3, 32'h1, 1, 4'hF, 6'd3, 32'hFFFFFFFF);
    idle();
    chk("coll_hi", coll[0], 1);
    idle();
    chk("coll_lo", coll[0], 0);
    drv(1, 4'h0, 6'd3, 0, 0, 0, 0, 0);
    idle(2);
    chk("coll_data", dout[0], 32'hFFFF0001);
    idle(2);

    drv(1, 4'hF, 6'd9, 32'h10, 0, 0, 0, 0);
    idle(3);
    drv(1, 4'hF, 6'd9, 32'h20, 1, 4'h0, 6'd9, 0);
    idle(2);
    chk("rf_a", dout[2], 32'h10);
    chk("rf_va", val[2], 1);
    chk("wf_a", dout[4], 32'h20);
    chk("nc_va", val[0], 0);
    chk("nc_hold", dout[0], 32'hFFFF0001);
    chk("nc_b", dout[1], 32'h10);
    chk("rf_b", dout[3], 32'h10);
    chk("wf_b", dout[5], 32'h10);
    idle(2);

    drv(1, 4'h0, 6'd25, 0, 0, 0, 0, 0);
    idle(3);
    chk("oor_val", val[6], 1);
    chk("oor_data", dout[6], 0);
    idle(2);

    drv(1, 4'h0, 6'd5, 0, 0, 0, 0, 0);
    rn = 1'b0;
    drv(1, 4'hF, 6'd10, 32'hCAFE0010, 0, 0, 0, 0);
    chk("rst_mid_dout", dout[6], 0);
    idle();
    chk("rst_mid_val", val[6], 0);
    rn = 1'b1;
    idle(5);
    drv(1, 4'h0, 6'd5, 0, 0, 0, 0, 0);
    drv(1, 4'h0, 6'd10, 0, 0, 0, 0, 0);
    idle(2);
    chk("rst_keep", dout[6], 32'hDEADBEEF);
    idle();
    chk("rst_wr", dout[6], 32'hCAFE0010);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 1),
          $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0,
          6'($urandom_range(18, 25)), $urandom,
          $urandom_range(0, 1),
          $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0,
          6'($urandom_range(18, 25)), $urandom);
    end
    idle(6);
    for (int k = 0; k < 8; k++)
      chk($sformatf("drain%0d", k), q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
